// File: rtl/display_scheduler_if.sv
// Request/data/display bundle between the display sources and the scheduler.
// The master drives requests and source data; the slave drives grant and digits.
interface display_scheduler_if;
  logic [3:0]   req;
  logic [127:0] value;
  logic [31:0]  en_mask;
  logic [31:0]  dp_mask;
  logic [3:0]   grant;
  logic [5:0]   d1;
  logic [5:0]   d2;
  logic [5:0]   d3;
  logic [5:0]   d4;
  logic [5:0]   d5;
  logic [5:0]   d6;
  logic [5:0]   d7;
  logic [5:0]   d8;
  logic         busy;

  modport master (
    output req, value, en_mask, dp_mask,
    input  grant, d1, d2, d3, d4, d5, d6, d7, d8, busy
  );

  modport slave (
    input  req, value, en_mask, dp_mask,
    output grant, d1, d2, d3, d4, d5, d6, d7, d8, busy
  );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of an 8-digit display among four sources; each
// grant holds the display for a fixed dwell unless its request drops.
module display_scheduler #(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned DWELL_TICKS = 1000
) (
  input logic               clock,
  input logic               reset,
  display_scheduler_if.slave sched_if
);

  localparam int unsigned NSRC    = 4;
  localparam int unsigned NDIG    = 8;
  localparam int unsigned DIGW    = 6;
  localparam int unsigned TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e               state_q, state_d;
  logic [NSRC-1:0]      grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 busy_q, busy_d;
  logic [DIGW-1:0]      d_q [NDIG];
  logic [DIGW-1:0]      d_d [NDIG];

  logic [31:0]          val_a [NSRC];
  logic [7:0]           en_a  [NSRC];
  logic [7:0]           dp_a  [NSRC];

  logic                 tick_wrap_c;
  logic                 expire_c;
  logic                 cur_req_c;
  logic [NSRC-1:0]      others_c;
  logic [1:0]           src_c;
  logic                 restart_c;
  logic [31:0]          sel_val_c;
  logic [7:0]           sel_en_c;
  logic [7:0]           sel_dp_c;

  // Split the packed source buses into per-source words.
  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign val_a[i] = sched_if.value[32*i +: 32];
    assign en_a[i]  = sched_if.en_mask[8*i +: 8];
    assign dp_a[i]  = sched_if.dp_mask[8*i +: 8];
  end

  // First requester strictly after `last`, wrapping; `last` itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [NSRC-1:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tick_d    = tick_q;
    dwell_d   = dwell_q;
    busy_d    = busy_q;
    src_c     = last_q;
    restart_c = 1'b0;

    tick_wrap_c = (tick_q == TICK_LAST);
    expire_c    = tick_wrap_c && (dwell_q == DWELL_LAST);
    cur_req_c   = |(sched_if.req & grant_q);
    others_c    = sched_if.req & ~grant_q;

    case (state_q)
      IDLE: begin
        if (|sched_if.req) begin
          state_d   = SHOW;
          src_c     = rr_pick(sched_if.req, last_q);
          restart_c = 1'b1;
        end
      end
      SHOW: begin
        if (expire_c || !cur_req_c) begin
          if (|others_c) begin
            src_c     = rr_pick(others_c, last_q);
            restart_c = 1'b1;
          end else if (cur_req_c) begin
            restart_c = 1'b1;
          end else begin
            state_d = IDLE;
            tick_d  = '0;
            dwell_d = '0;
          end
        end else if (tick_wrap_c) begin
          tick_d  = '0;
          dwell_d = dwell_q + DWELL_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart_c) begin
      grant_d = NSRC'(1) << src_c;
      last_d  = src_c;
      tick_d  = '0;
      dwell_d = '0;
    end
    if (state_d == IDLE) begin
      grant_d = '0;
    end
    busy_d = (state_d == SHOW);

    // Digit K (0 = leftmost) takes the highest remaining nibble and mask bit.
    sel_val_c = val_a[src_c];
    sel_en_c  = en_a[src_c];
    sel_dp_c  = dp_a[src_c];
    for (int k = 0; k < NDIG; k++) begin
      d_d[k] = '0;
      if (state_d == SHOW) begin
        d_d[k] = {sel_en_c[7-k], sel_val_c[28-4*k +: 4], sel_dp_c[7-k]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd3;
      tick_q  <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tick_q  <= tick_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      for (int k = 0; k < NDIG; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign sched_if.grant = grant_q;
  assign sched_if.busy  = busy_q;
  assign sched_if.d1    = d_q[0];
  assign sched_if.d2    = d_q[1];
  assign sched_if.d3    = d_q[2];
  assign sched_if.d4    = d_q[3];
  assign sched_if.d5    = d_q[4];
  assign sched_if.d6    = d_q[5];
  assign sched_if.d7    = d_q[6];
  assign sched_if.d8    = d_q[7];

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter TICK_CYCLES, default 100000, clock cycles per dwell tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 Parameter DWELL_TICKS, default 1000, ticks a granted source holds the display; legal range 1..2^16.
REQ-003 clock  in  1  system clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 req  in  4  request per source i; level, held while the source wants display time.
REQ-006 value  in  128  eight hex nibbles per source; source i at [32i+31:32i], nibble [31:28] is the leftmost digit.
REQ-007 en_mask  in  32  digit-enable bits per source; source i at [8i+7:8i], bit 7 is the leftmost digit.
REQ-008 dp_mask  in  32  decimal-point bits per source, active-high, same packing as en_mask.
REQ-009 grant  out  4  one-hot grant, or all zero when idle.
REQ-010 d1..d8  out  6 each  digit words for the 8-digit display driver, {enable, hex[3:0], dp}; d1 is leftmost.
REQ-011 busy  out  1  high while any source holds a grant.

Function
REQ-012 The block SHALL implement two states, IDLE and SHOW, in a state register.
REQ-013 In IDLE, grant, busy and every dK SHALL be 0; all digits are therefore blanked.
REQ-014 In IDLE, if any req bit is high at a rising edge, the block SHALL enter SHOW on that edge and grant the source selected by round-robin arbitration.
REQ-015 Round-robin SHALL search from (last granted index + 1) mod 4 upward with wrap-around; after reset the last granted index SHALL be 3, so source 0 wins first.
REQ-016 grant, busy and the first dK update SHALL take effect on the same edge that enters SHOW (one-cycle request-to-grant latency).
REQ-017 In SHOW, dK SHALL be registered every cycle from the granted source as {en_mask[8i+8-K], value[32i+35-4K:32i+32-4K], dp_mask[8i+8-K]}, so changes to the granted source's data appear after one cycle.
REQ-018 A tick counter SHALL count 0..TICK_CYCLES-1 and wrap; a tick occurs on the wrap; the counter SHALL be cleared on every new grant.
REQ-019 A dwell counter SHALL count ticks from 0 and SHALL be cleared on every new grant; dwell expires when it reaches DWELL_TICKS, i.e. exactly DWELL_TICKS*TICK_CYCLES cycles after the grant edge.
REQ-020 A release event SHALL occur when dwell expires or when req of the granted source is low.
REQ-021 On release, if any other source requests, the block SHALL grant the next one by round-robin on the same edge, with no IDLE cycle in between.
REQ-022 On release with no other requester and the granted source still requesting (dwell expiry only), the grant SHALL be kept and both counters restarted.
REQ-023 On release with no requester at all, the block SHALL return to IDLE on that edge and blank all outputs.
REQ-024 When dwell expiry and deassertion of the granted req coincide, the behaviour SHALL be identical to deassertion alone.
REQ-025 grant SHALL never have more than one bit set, and SHALL never change other than on a release event.

Reset
REQ-026 Asserting reset at any time, including mid-SHOW, SHALL immediately set state=IDLE, grant=0, busy=0, d1..d8=0, both counters=0, and last granted index=3.
REQ-027 After reset deasserts, the first grant SHALL follow REQ-014/015, with no carry-over of dwell.

Verification (TICK_CYCLES=4, DWELL_TICKS=3, so a dwell is 12 cycles)
REQ-028 Reset, then req=0001, value[31:0]=0x1234ABCD, en_mask[7:0]=0xFF, dp_mask[7:0]=0x01 -> grant=0001 one cycle later; d1=6'b1_0001_0, d8=6'b1_1101_1; busy=1.
REQ-029 req=0101 held -> grant alternates 0001 and 0100, each held exactly 12 cycles, with no idle cycle between grants.
REQ-030 req=0010 held alone -> grant stays 0010 beyond 12 cycles and dwell restarts; then drop req -> IDLE next edge, all dK=0, busy=0.
REQ-031 Source 2 granted with req=0100, then req changes to 1000 mid-dwell -> grant=1000 on the next edge; with req=1001 from idle after source 3's grant, source 0 wins (wrap-around).
REQ-032 Assert reset during SHOW at cycle 5 of a dwell -> outputs immediately 0, asynchronously; after release with req=1111 -> grant=0001.
REQ-033 Coincident dwell expiry and granted-req drop with req otherwise 0 -> IDLE, not a re-grant; a checker asserts that grant is one-hot-or-zero on every cycle.
